// File: rtl/shiftregister_serial_tx_if.sv
// Load handshake, shift control and serial/framing outputs of the serial transmitter.
// master = word source / shift controller, slave = transmitter.
interface shiftregister_serial_tx_if #(
    parameter int WIDTH = 5
);
    logic             loadValid;
    logic [WIDTH-1:0] loadData;
    logic             shiftEnable;
    logic             loadReady;
    logic             serialOut;
    logic             serialValid;
    logic             busy;
    logic             frameDone;

    modport master (
        output loadValid, loadData, shiftEnable,
        input  loadReady, serialOut, serialValid, busy, frameDone
    );

    modport slave (
        input  loadValid, loadData, shiftEnable,
        output loadReady, serialOut, serialValid, busy, frameDone
    );
endinterface

// File: rtl/shiftregister_serial_tx.sv
// Parallel-in/serial-out transmitter, MSB first: first bit the cycle after load, frameDone the cycle after the last bit.
// Backpressure: shiftEnable=0 freezes the frame; loadReady only in IDLE or on an enabled last-bit cycle.
module shiftregister_serial_tx #(
    parameter int WIDTH = 5
) (
    input logic                      clockpulse,
    input logic                      clear,
    shiftregister_serial_tx_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SHIFT = 1'b1;

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_bit_count;
    logic             r_frame_done;

    logic w_shifting;
    logic w_last;
    logic w_ready;
    logic w_accept;

    assign w_shifting = (r_state == S_SHIFT);
    // Last enabled bit cycle: the next word may be taken here so frames run back-to-back.
    assign w_last     = w_shifting && (r_bit_count == '0) && bus.shiftEnable;
    assign w_ready    = clear && ((r_state == S_IDLE) || w_last);
    assign w_accept   = bus.loadValid && w_ready;

    always_ff @(posedge clockpulse or negedge clear) begin
        if (!clear) begin
            r_state      <= S_IDLE;
            r_shreg      <= '0;
            r_bit_count  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept) begin
                    r_shreg     <= bus.loadData;
                    r_bit_count <= LAST_IDX;
                    r_state     <= S_SHIFT;
                end
            end else if (bus.shiftEnable) begin
                if (r_bit_count != '0) begin
                    r_shreg     <= {r_shreg[WIDTH-2:0], 1'b0};
                    r_bit_count <= r_bit_count - CW'(1);
                end else begin
                    r_frame_done <= 1'b1;
                    if (w_accept) begin
                        r_shreg     <= bus.loadData;
                        r_bit_count <= LAST_IDX;
                    end else begin
                        r_state <= S_IDLE;
                        r_shreg <= '0;
                    end
                end
            end
        end
    end

    assign bus.loadReady   = w_ready;
    assign bus.serialOut   = w_shifting && r_shreg[WIDTH-1];
    assign bus.serialValid = w_shifting;
    assign bus.busy        = w_shifting;
    assign bus.frameDone   = r_frame_done;
endmodule

// File: tb/tb_shiftregister_serial_tx.sv
// Bench for shiftregister_serial_tx: queue-based reference model compared every cycle for WIDTH=5 and WIDTH=8,
// plus directed frames with hand-written bit sequences.
module tb_shiftregister_serial_tx;
    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    shiftregister_serial_tx_if #(.WIDTH(5)) b5();
    shiftregister_serial_tx_if #(.WIDTH(8)) b8();

    shiftregister_serial_tx #(.WIDTH(5)) dut5 (.clockpulse(clk), .clear(clear), .bus(b5));
    shiftregister_serial_tx #(.WIDTH(8)) dut8 (.clockpulse(clk), .clear(clear), .bus(b8));

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_on   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // Model: queue of bits still to be sent, front = bit currently on the line.
    bit   mq5[$];
    bit   mq8[$];
    bit   md5, md8;
    bit   acc5, acc8;
    logic [4:0] e5, e8;
    logic [4:0] rx5 = '0;

    always @(posedge clk or negedge clear) begin
        if (!clear) begin
            mq5.delete(); md5 = 1'b0;
            mq8.delete(); md8 = 1'b0;
        end else begin
            acc5 = b5.loadValid && (mq5.size() == 0 || (mq5.size() == 1 && b5.shiftEnable));
            md5  = (mq5.size() == 1) && b5.shiftEnable;
            if (mq5.size() > 0 && b5.shiftEnable) void'(mq5.pop_front());
            if (acc5) for (int i = 4; i >= 0; i--) mq5.push_back(b5.loadData[i]);

            acc8 = b8.loadValid && (mq8.size() == 0 || (mq8.size() == 1 && b8.shiftEnable));
            md8  = (mq8.size() == 1) && b8.shiftEnable;
            if (mq8.size() > 0 && b8.shiftEnable) void'(mq8.pop_front());
            if (acc8) for (int i = 7; i >= 0; i--) mq8.push_back(b8.loadData[i]);
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            e5 = {clear && (mq5.size() == 0 || (mq5.size() == 1 && b5.shiftEnable)),
                  (mq5.size() > 0) ? mq5[0] : 1'b0, mq5.size() > 0, mq5.size() > 0, md5};
            chk("model_w5", 32'({b5.loadReady, b5.serialOut, b5.serialValid, b5.busy, b5.frameDone}), 32'(e5));
            e8 = {clear && (mq8.size() == 0 || (mq8.size() == 1 && b8.shiftEnable)),
                  (mq8.size() > 0) ? mq8[0] : 1'b0, mq8.size() > 0, mq8.size() > 0, md8};
            chk("model_w8", 32'({b8.loadReady, b8.serialOut, b8.serialValid, b8.busy, b8.frameDone}), 32'(e8));
            if (b5.serialValid && b5.shiftEnable) rx5 = {rx5[3:0], b5.serialOut};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [9:0] seq;

        clear = 1'b0;
        b5.loadValid = 1'b0; b5.loadData = '0; b5.shiftEnable = 1'b1;
        b8.loadValid = 1'b0; b8.loadData = '0; b8.shiftEnable = 1'b1;
        tick(); tick();
        chk_on = 1'b1;
        chk("reset_outputs", 32'({b5.loadReady, b5.serialOut, b5.serialValid, b5.busy, b5.frameDone}), 32'd0);
        clear = 1'b1;
        #1;
        chk("ready_after_release", 32'(b5.loadReady), 32'd1);
        tick();

        // Single frame 10110
        b5.loadValid = 1'b1; b5.loadData = 5'b10110;
        tick();
        b5.loadValid = 1'b0; b5.loadData = 5'b00000;
        seq = 10'b00000_10110;
        for (int k = 1; k <= 5; k++) begin
            chk($sformatf("single_bit%0d", k), 32'({b5.serialOut, b5.serialValid, b5.frameDone}),
                32'({seq[5-k], 1'b1, 1'b0}));
            tick();
        end
        chk("single_done", 32'({b5.serialValid, b5.busy, b5.frameDone}), 32'b001);
        tick();
        chk("single_done_once", 32'(b5.frameDone), 32'd0);
        chk("single_receiver", 32'(rx5), 32'(5'b10110));

        // Back-to-back 00001 then 11000
        b5.loadValid = 1'b1; b5.loadData = 5'b00001;
        tick();
        b5.loadData = 5'b11000;
        seq = 10'b00001_11000;
        for (int k = 1; k <= 10; k++) begin
            if (k == 6) b5.loadValid = 1'b0;
            chk($sformatf("b2b_bit%0d", k), 32'({b5.serialOut, b5.serialValid, b5.frameDone}),
                32'({seq[10-k], 1'b1, (k == 6)}));
            if (k == 3) chk("b2b_ready_mid", 32'(b5.loadReady), 32'd0);
            if (k == 5) chk("b2b_ready_last", 32'(b5.loadReady), 32'd1);
            tick();
        end
        chk("b2b_done2", 32'({b5.serialValid, b5.frameDone}), 32'b01);
        tick();

        // Stall: 10011 with shiftEnable low for 3 cycles after the 2nd bit
        b5.loadValid = 1'b1; b5.loadData = 5'b10011;
        tick();
        b5.loadValid = 1'b0;
        seq = 10'b00_10000011;
        for (int k = 1; k <= 8; k++) begin
            if (k == 3) b5.shiftEnable = 1'b0;
            if (k == 6) b5.shiftEnable = 1'b1;
            chk($sformatf("stall_bit%0d", k), 32'({b5.serialOut, b5.serialValid, b5.frameDone}),
                32'({seq[8-k], 1'b1, 1'b0}));
            tick();
        end
        chk("stall_done", 32'({b5.serialValid, b5.frameDone}), 32'b01);
        tick();
        chk("stall_done_once", 32'(b5.frameDone), 32'd0);

        // Load offered mid-frame must be ignored
        b5.loadValid = 1'b1; b5.loadData = 5'b01010;
        tick();
        b5.loadValid = 1'b0;
        seq = 10'b00000_01010;
        for (int k = 1; k <= 5; k++) begin
            if (k == 2) begin b5.loadValid = 1'b1; b5.loadData = 5'b11111; end
            if (k == 3) b5.loadValid = 1'b0;
            chk($sformatf("ignore_bit%0d", k), 32'({b5.serialOut, b5.serialValid, b5.frameDone}),
                32'({seq[5-k], 1'b1, 1'b0}));
            if (k == 2) chk("ignore_ready", 32'(b5.loadReady), 32'd0);
            tick();
        end
        chk("ignore_done", 32'({b5.serialValid, b5.frameDone}), 32'b01);
        tick();
        chk("ignore_no_accept", 32'(b5.busy), 32'd0);

        // Asynchronous reset mid-frame
        b5.loadValid = 1'b1; b5.loadData = 5'b10110;
        tick();
        b5.loadValid = 1'b0;
        tick(); tick();
        chk("pre_reset_bit3", 32'(b5.serialOut), 32'd1);
        #2 clear = 1'b0;
        #1;
        chk("async_reset_outputs", 32'({b5.loadReady, b5.serialOut, b5.serialValid, b5.busy, b5.frameDone}), 32'd0);
        @(posedge clk);
        #1 clear = 1'b1;
        #1;
        chk("reset_release_ready", 32'(b5.loadReady), 32'd1);
        for (int k = 0; k < 7; k++) begin
            tick();
            chk($sformatf("reset_no_done%0d", k), 32'({b5.busy, b5.frameDone}), 32'd0);
        end

        // WIDTH=8 frame A5
        b8.loadValid = 1'b1; b8.loadData = 8'hA5;
        tick();
        b8.loadValid = 1'b0;
        seq = 10'b00_10100101;
        for (int k = 1; k <= 8; k++) begin
            chk($sformatf("w8_bit%0d", k), 32'({b8.serialOut, b8.serialValid, b8.frameDone}),
                32'({seq[8-k], 1'b1, 1'b0}));
            tick();
        end
        chk("w8_done", 32'({b8.serialValid, b8.frameDone}), 32'b01);
        tick();
        chk("w8_idle", 32'({b8.busy, b8.frameDone}), 32'd0);

        chk_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
